// File: rtl/dma_io_dev_pkg.sv
// Shared constants and types for the DMA I/O peripheral: bus polarities,
// register offsets, CTRL bit indices and the dreq_ state encoding.
package dma_io_dev_pkg;

  localparam int DIO_BUS_ADDR_WIDTH = 10;
  localparam int DIO_DATA_WIDTH     = 8;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam logic [1:0] DIO_DATA = 2'd0;
  localparam logic [1:0] DIO_STAT = 2'd1;
  localparam logic [1:0] DIO_CNT  = 2'd2;
  localparam logic [1:0] DIO_CTRL = 2'd3;

  localparam int CTRL_CLR   = 0;
  localparam int CTRL_RX_EN = 1;
  localparam int CTRL_TX_EN = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } dreq_state_t;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } dma_dir_t;

  // Clamp a FIFO level into a 4-bit COUNT field.
  function automatic logic [3:0] sat4(input logic [31:0] v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/dma_io_fifo.sv
// Synchronous FIFO with simultaneous push/pop and a synchronous flush.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; rdata shows the head entry combinationally.
module dma_io_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Pointers and level; flush wins over any same-cycle traffic.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage array, not reset; contents are only visible through valid levels.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dma_io_dev.sv
// DMA-capable I/O peripheral: bus slave with a 4-register window, RX/TX
// FIFOs toward the device, and the requesting side of dreq_/eop_.
//
// state  | meaning
// IDLE   | dreq_ high, evaluating RX fill / TX free against THRESH
// REQ    | dreq_ low, waiting for eop_ from the DMA controller
// HOLD   | dreq_ high for one clock after eop_ before re-evaluating
module dma_io_dev
  import dma_io_dev_pkg::*;
#(
  parameter int            AW        = DIO_BUS_ADDR_WIDTH,
  parameter int            DW        = DIO_DATA_WIDTH,
  parameter logic [AW-1:0] BASE_ADDR = AW'(32'h020),
  parameter int            DEPTH     = 8,
  parameter int            THRESH    = 4
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] idata,
  output logic [DW-1:0] odata,
  input  logic          rw_,
  input  logic          as_,
  output logic          dreq_,
  input  logic          eop_,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready
);

  localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  logic [AW-1:0] off_full;
  logic [1:0]    off;
  logic          hit, rd, wr, data_rd, data_wr, ctrl_wr, clr;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0] rx_count, tx_count, tx_free;
  logic [DW-1:0] rx_rdata, tx_rdata;
  logic          rx_en, tx_en, ovf, unf;
  logic          rx_cond, tx_cond;
  logic [7:0]    stat_byte, cnt_byte, ctrl_byte;
  dreq_state_t   state, state_nxt;
  dma_dir_t      dir, dir_nxt;

  // Unsigned offset: addresses below BASE_ADDR wrap high and miss the window.
  assign off_full = addr - BASE_ADDR;
  assign off      = off_full[1:0];
  assign hit      = (as_ == ENABLE_) && (off_full < AW'(4));
  assign rd       = hit && (rw_ == READ);
  assign wr       = hit && (rw_ == WRITE);
  assign data_rd  = rd && (off == DIO_DATA);
  assign data_wr  = wr && (off == DIO_DATA);
  assign ctrl_wr  = wr && (off == DIO_CTRL);
  assign clr      = ctrl_wr && idata[CTRL_CLR];

  dma_io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset_(reset_), .clr(clr),
    .push(rx_valid), .pop(data_rd), .wdata(rx_data), .rdata(rx_rdata),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  dma_io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset_(reset_), .clr(clr),
    .push(data_wr), .pop(tx_ready), .wdata(idata), .rdata(tx_rdata),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_rdata;
  assign tx_free  = CW'(DEPTH) - tx_count;

  assign stat_byte = {tx_full, tx_empty, rx_full, rx_empty, ovf, unf, 2'b00};
  assign cnt_byte  = {sat4(32'(rx_count)), sat4(32'(tx_count))};
  assign ctrl_byte = {5'b0, tx_en, rx_en, 1'b0};

  // CTRL enables and sticky error flags; clear drops the flags.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rx_en <= 1'b0;
      tx_en <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_en <= idata[CTRL_RX_EN];
        tx_en <= idata[CTRL_TX_EN];
      end
      if (clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if ((rx_valid && rx_full && !data_rd) || (data_wr && tx_full && !tx_ready))
          ovf <= 1'b1;
        if (data_rd && rx_empty)
          unf <= 1'b1;
      end
    end
  end

  // Registered read data, updated only on read hits.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      odata <= '0;
    end else if (rd) begin
      case (off)
        DIO_DATA: odata <= rx_empty ? '0 : rx_rdata;
        DIO_STAT: odata <= DW'(stat_byte);
        DIO_CNT:  odata <= DW'(cnt_byte);
        default:  odata <= DW'(ctrl_byte);
      endcase
    end
  end

  assign rx_cond = rx_en && (rx_count >= CW'(THRESH));
  assign tx_cond = tx_en && (tx_free >= CW'(THRESH));

  // Request FSM next-state; RX wins when both directions qualify.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    case (state)
      S_IDLE: begin
        if (!clr && rx_cond) begin
          state_nxt = S_REQ;
          dir_nxt   = DIR_RX;
        end else if (!clr && tx_cond) begin
          state_nxt = S_REQ;
          dir_nxt   = DIR_TX;
        end
      end
      S_REQ: begin
        if (clr)                                      state_nxt = S_IDLE;
        else if (eop_ == ENABLE_)                     state_nxt = S_HOLD;
        else if ((dir == DIR_RX) ? !rx_en : !tx_en)   state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, latched direction and the glitch-free registered dreq_.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= S_IDLE;
      dir   <= DIR_RX;
      dreq_ <= DISABLE_;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      dreq_ <= (state_nxt == S_REQ) ? ENABLE_ : DISABLE_;
    end
  end

endmodule

// File: tb/tb_dma_io_dev.sv
// Directed bench for dma_io_dev: bus reads queue their expected odata, and a
// monitor compares odata one step after each read-hit clock edge.
module tb_dma_io_dev;

  localparam logic [9:0] BASE = 10'h020;
  localparam logic [1:0] O_DATA = 2'd0, O_STAT = 2'd1, O_CNT = 2'd2, O_CTRL = 2'd3;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic [9:0] addr = '0;
  logic [7:0] idata = '0;
  logic [7:0] odata;
  logic       rw_ = 1'b1;
  logic       as_ = 1'b1;
  logic       dreq_;
  logic       eop_ = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  string      name_q [$];

  dma_io_dev dut (
    .clk(clk), .reset_(reset_), .addr(addr), .idata(idata), .odata(odata),
    .rw_(rw_), .as_(as_), .dreq_(dreq_), .eop_(eop_),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Monitor: every read-hit edge produces odata one step later.
  always @(posedge clk) begin
    if (reset_ && !as_ && rw_) begin
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: odata=%h with no queued expectation", odata);
      end else begin
        logic [7:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (odata !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", n, odata, e);
        end
      end
    end
  end

  task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
    addr = BASE + 10'(off); idata = d; rw_ = 1'b0; as_ = 1'b0;
    tick();
    as_ = 1'b1; rw_ = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] off, input logic [7:0] e, input string n);
    exp_q.push_back(e); name_q.push_back(n);
    addr = BASE + 10'(off); rw_ = 1'b1; as_ = 1'b0;
    tick();
    as_ = 1'b1;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rxv [4];
    rxv[0] = 8'h11; rxv[1] = 8'h22; rxv[2] = 8'h33; rxv[3] = 8'h44;

    tick(); tick();
    reset_ = 1'b1;
    check("rst_dreq", {7'b0, dreq_}, 8'h01);
    check("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_odata", odata, 8'h00);
    bus_read(O_STAT, 8'h50, "rst_status");

    // RX burst
    bus_write(O_CTRL, 8'h02);
    for (int i = 0; i < 4; i++) rx_push(rxv[i]);
    check("rx_dreq_latency", {7'b0, dreq_}, 8'h01);
    tick();
    check("rx_dreq_low", {7'b0, dreq_}, 8'h00);
    bus_read(O_CTRL, 8'h02, "ctrl_readback");
    for (int i = 0; i < 4; i++) bus_read(O_DATA, rxv[i], "rx_data_pop");
    check("rx_dreq_held", {7'b0, dreq_}, 8'h00);
    eop_ = 1'b0; tick(); eop_ = 1'b1;
    check("eop_hold", {7'b0, dreq_}, 8'h01);
    tick();
    check("eop_gap2", {7'b0, dreq_}, 8'h01);
    tick();
    check("rx_empty_idle", {7'b0, dreq_}, 8'h01);

    // TX request
    bus_write(O_CTRL, 8'h04);
    check("tx_dreq_latency", {7'b0, dreq_}, 8'h01);
    tick();
    check("tx_dreq_low", {7'b0, dreq_}, 8'h00);
    addr = BASE; idata = 8'h42; rw_ = 1'b0; as_ = 1'b0; eop_ = 1'b0;
    tick();
    as_ = 1'b1; rw_ = 1'b1; eop_ = 1'b1;
    check("tx_valid", {7'b0, tx_valid}, 8'h01);
    check("tx_data", tx_data, 8'h42);
    check("tx_eop_dreq", {7'b0, dreq_}, 8'h01);
    bus_write(O_CTRL, 8'h00);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("tx_popped", {7'b0, tx_valid}, 8'h00);
    check("tx_disabled_dreq", {7'b0, dreq_}, 8'h01);

    // RX overflow with rx_en=0
    for (int i = 0; i < 8; i++) begin
      check("rx_ready_before_full", {7'b0, rx_ready}, 8'h01);
      rx_push(8'(8'h80 + i));
    end
    check("rx_ready_full", {7'b0, rx_ready}, 8'h00);
    rx_push(8'hEE);
    check("ovf_no_dreq", {7'b0, dreq_}, 8'h01);
    bus_read(O_STAT, 8'h68, "ovf_status");
    bus_read(O_CNT, 8'h80, "full_count");
    bus_write(O_CTRL, 8'h01);
    bus_read(O_CTRL, 8'h00, "clr_selfclear");
    bus_read(O_STAT, 8'h50, "clr_status");

    // Underflow and simultaneous RX push/pop
    bus_read(O_DATA, 8'h00, "unf_data");
    bus_read(O_STAT, 8'h54, "unf_status");
    bus_write(O_CTRL, 8'h01);
    rx_push(8'hAA); rx_push(8'hBB); rx_push(8'hCC);
    exp_q.push_back(8'hAA); name_q.push_back("simul_pop");
    addr = BASE; rw_ = 1'b1; as_ = 1'b0; rx_data = 8'hDD; rx_valid = 1'b1;
    tick();
    as_ = 1'b1; rx_valid = 1'b0;
    bus_read(O_CNT, 8'h30, "simul_level");
    bus_read(O_DATA, 8'hBB, "simul_next1");
    bus_read(O_DATA, 8'hCC, "simul_next2");
    bus_read(O_DATA, 8'hDD, "simul_pushed");

    // TX overflow with tx_en=0
    for (int i = 0; i < 9; i++) bus_write(O_DATA, 8'(8'h60 + i));
    bus_read(O_STAT, 8'h98, "tx_ovf_status");
    bus_read(O_CNT, 8'h08, "tx_full_count");
    check("tx_head_kept", tx_data, 8'h60);
    tx_ready = 1'b1; addr = BASE; idata = 8'h77; rw_ = 1'b0; as_ = 1'b0;
    tick();
    tx_ready = 1'b0; as_ = 1'b1; rw_ = 1'b1;
    bus_read(O_CNT, 8'h08, "tx_full_pushpop");
    check("tx_head_adv", tx_data, 8'h61);

    // Reset mid-burst
    bus_write(O_CTRL, 8'h01);
    bus_write(O_CTRL, 8'h02);
    for (int i = 0; i < 4; i++) rx_push(8'(8'h10 + i));
    tick();
    check("mid_dreq_low", {7'b0, dreq_}, 8'h00);
    #2 reset_ = 1'b0;
    #1 check("mid_reset_dreq", {7'b0, dreq_}, 8'h01);
    check("mid_reset_rx_ready", {7'b0, rx_ready}, 8'h01);
    tick();
    reset_ = 1'b1;
    bus_read(O_CNT, 8'h00, "post_reset_count");
    bus_read(O_STAT, 8'h50, "post_reset_status");
    bus_read(O_CTRL, 8'h00, "post_reset_ctrl");
    tick(); tick();
    check("post_reset_dreq", {7'b0, dreq_}, 8'h01);
    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_io_dev.md
Name: dma_io_dev

Overview:
- DMA-capable I/O peripheral: the requesting end of the dreq_/eop_ handshake that the DMA controller services. It is also a bus slave answering accesses in its address window.
- Buffers inbound device data (RX) for IO-to-memory transfers and outbound data (TX) for memory-to-IO transfers.
- Raises dreq_ when a burst's worth of work is ready and releases it on eop_.
- Sits beside the memory and counter slaves on the shared addr/idata/odata/rw_ bus.

Parameters:
- BASE_ADDR, 10'h020: window base; window = BASE_ADDR..BASE_ADDR+3.
- AW, `BUS_ADDR_WIDTH (10): bus address width.
- DW, `DATA_WIDTH (8): data width.
- DEPTH, 8: entries per FIFO; power of two, at least 2.
- THRESH, 4: RX fill level / TX free level that triggers dreq_; 1 ≤ THRESH ≤ DEPTH.

Ports:
- clk  in  1  clock, rising edge
- reset_  in  1  asynchronous reset, active-low (`Enable_ = 0)
- addr  in  AW  bus address
- idata  in  DW  bus write data
- odata  out  DW  bus read data
- rw_  in  1  `Read=1 / `Write=0
- as_  in  1  bus access strobe, active-low; one access per clock with as_ low
- dreq_  out  1  DMA request, active-low
- eop_  in  1  end-of-transfer from DMA, active-low
- rx_data  in  DW  device-side inbound data
- rx_valid  in  1  inbound data present
- rx_ready  out  1  RX FIFO not full
- tx_data  out  DW  device-side outbound data (TX FIFO head)
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  device consumes head

Behaviour:
- Reset (async, reset_ low):
  - FIFOs empty; CTRL=0; overflow/underflow flags 0.
  - odata=0, dreq_=`Disable_ (1), rx_ready=1, tx_valid=0, tx_data=0.
- Hit: as_ low and addr−BASE_ADDR in 0..3.
- Register map (offset):
  - 0 DATA: read pops RX; write pushes TX.
  - 1 STATUS (read-only): {tx_full, tx_empty, rx_full, rx_empty, ovf, unf, 2'b0}; writes ignored.
  - 2 COUNT (read-only): {rx_count[3:0], tx_count[3:0]} for DEPTH≤8, each saturating to the field.
  - 3 CTRL (R/W): bit0 clear (self-clearing; empties both FIFOs and clears ovf/unf), bit1 rx_en, bit2 tx_en, others read 0.
- Read latency:
  - odata is registered, valid the clock after the hit, and holds until the next read hit.
  - Non-hit cycles leave odata unchanged.
- FIFO access rules:
  - A read of DATA on empty RX returns 0, sets sticky unf, no pop.
  - A write of DATA on full TX drops the data, sets sticky ovf.
  - rx_valid with RX full drops the data and sets ovf (rx_ready=0 warns the device).
  - Same-cycle device push and bus pop on RX are both honoured, level unchanged; the same holds for TX with tx_ready and bus write.
  - A full FIFO with simultaneous push and pop accepts both.
  - Pointers wrap modulo DEPTH; count is ⌈log2 DEPTH⌉+1 bits wide.
- dreq_ FSM, states IDLE, REQ, HOLD:
  - IDLE→REQ when (rx_en && rx_count≥THRESH) || (tx_en && tx_free≥THRESH). The cause is latched in dir (RX priority if both).
  - REQ: dreq_=0. Stays until eop_ sampled 0 → HOLD. Bus accesses continue normally meanwhile.
  - HOLD: dreq_=1 for exactly one clock → IDLE, where the condition is re-evaluated next clock. Minimum deassert gap is 2 clocks.
  - Clearing the latched dir's enable bit in REQ → IDLE, dreq_=1 next clock.
  - A clear in CTRL forces the FSM to IDLE.
  - eop_ in IDLE/HOLD is ignored.
- Reset mid-burst: immediate dreq_=1, FIFOs discarded.
- dreq_ is registered: asserted the clock after the condition becomes true.

Decomposition:
- Shared define header (existing): `BUS_ADDR_WIDTH, `DATA_WIDTH, `Enable_/`Disable_, `Read/`Write.
- Add there: DIO register offsets (`DIO_DATA, `DIO_STAT, `DIO_CNT, `DIO_CTRL), CTRL bit indices, FSM state encodings.
- One sub-module, dma_io_fifo (parameters DW, DEPTH):
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Simultaneous push/pop allowed.
  - Instantiated twice, for RX and TX.

Test Plan:
- Reset then read STATUS → odata=8'h50 (tx_empty, rx_empty) one clock after the read; dreq_=1.
- CTRL=8'h02, push 4 RX bytes 11,22,33,44 via rx_valid → dreq_=0 the clock after the 4th push. Bus reads DATA x4 return 11,22,33,44. eop_ pulse → dreq_=1 for ≥2 clocks. RX empty → dreq_ stays 1.
- CTRL=8'h04 with TX empty → dreq_=0 (free=8≥4). Bus write 42 to DATA plus eop_ → tx_valid=1, tx_data=42. tx_ready pops → tx_valid=0.
- Push 9 RX bytes with rx_en=0 → rx_ready=0 after the 8th; 9th dropped; STATUS ovf=1; COUNT=8'h80. CTRL=8'h01 → STATUS=8'h50.
- Read DATA with RX empty → odata=0, unf set. Simultaneous rx_valid push and bus pop on RX level 3 → level stays 3.
- dreq_ low, assert reset_=0 mid-burst → dreq_=1 immediately, COUNT=0 after release.
